mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative RV32M multiply/divide unit for the CA2 processor datapath. Consumes the two register-file read operands (RD1/RD2), computes one M-extension operation over multiple cycles, and presents the 32-bit result with its destination register index and a one-cycle write strobe. These outputs drive the register-file write port (WD, A3, Reg_write). Control stalls issue while `busy` is high.

## Interface
- No parameters. Width fixed at 32 bits, iteration count fixed at 32.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when idle (`busy`=0).
- `funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val` input 32: operand A (dividend / multiplicand), from RD1.
- `rs2_val` input 32: operand B (divisor / multiplier), from RD2.
- `rd` input 5: destination index, captured with operands.
- `busy` output 1: high while an operation is in progress; new `start` is ignored.
- `done` output 1: one-cycle pulse, result valid; used as Reg_write.
- `result` output 32: result, held stable until the next `done`.
- `rd_out` output 5: captured `rd`, held with `result`; used as A3.

## Operation
- States are IDLE, CALC, FIX and DONE. `busy` = (state is CALC or FIX).
- IDLE: if `start`=1, capture `funct3`, `rs1_val`, `rs2_val` and `rd`, load iteration counter to 0, then go to CALC. Otherwise remain in IDLE.
- Signedness:
  - Signed operands are DIV/REM (both operands), MULH (both) and MULHSU (rs1 only).
  - Each signed operand is converted to its magnitude at capture. The result sign is recorded: for products, XOR of the operand signs; for quotients, XOR of the signs; for remainders, the dividend sign.
- CALC, multiply: shift-add over a 64-bit product register, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division with 32-bit remainder and quotient, one quotient bit per cycle, MSB first.
- CALC leaves after counter value 31 (32 cycles) and goes to FIX.
- FIX: negate the magnitude if the recorded sign is negative. Select the result:
  - MUL: low 32 bits of the product.
  - MULH, MULHSU, MULHU: high 32 bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Then go to DONE.
- DONE: `done`=1, `result` and `rd_out` registered. Next state is IDLE, or CALC if `start`=1 in this cycle (back-to-back issue is allowed).
- Special cases, required results:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = rs1_val.
  - DIV overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- `rd`=0 still completes and pulses `done`. The register file discards writes to x0.
- Reset mid-operation: at the next edge, return to IDLE. `done` is not pulsed; `busy`, `done`, `result` and `rd_out` are cleared.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0.
- `start` sampled at edge E0 → `busy`=1 from E0 until E33. `done`=1 for the single cycle E33–E34. Latency is 33 edges for every op (without early-out).
- `result` and `rd_out` change only at the edge that raises `done`.
- Operand or `funct3` changes after E0 have no effect.
- `start` while `busy`=1 is dropped; no queuing.

## Configuration
- `MDU_EARLY_OUT_EN` defined:
  - Divide by zero, DIV overflow, or any multiply with an operand equal to 0 bypasses CALC/FIX. The path is IDLE → DONE, so `done` is high in cycle E1–E2 (latency 1 edge).
  - `busy` stays 0 throughout, and the results are the special-case values above.
- Macro undefined: all operations take the full 33-edge path. Special-case results still come out of the iterative datapath, plus an explicit FIX override for divide by zero and overflow. The values are identical.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD), rd=5 → `done` at E33, `result`=0xFFFFFFEB, `rd_out`=5.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU (−1, 0xFFFFFFFF) → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIV 0x80000000 / −1 → 0x80000000. DIVU 5 / 0 → 0xFFFFFFFF. REM 5 / 0 → 5. With `MDU_EARLY_OUT_EN`, each of these gives `done` at E1.
- Second `start` at E10 with different operands → ignored, and the first result is unchanged. `start` held high during DONE → the next op is accepted, `busy` is high the following cycle, and its `done` arrives 33 edges later.
- `rst` asserted at E15 mid-DIV → IDLE at E16, no `done` pulse, `result`=0, `busy`=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit, one bit per cycle.
// Ports: clk, rst (sync, active-high) | start, funct3, rs1_val, rs2_val, rd
//   request | busy (issue stall) | done (Reg_write), result (WD), rd_out (A3).
// Option MDU_EARLY_OUT_EN: a multiply by zero, a divide by zero or a signed
//   divide overflow skips the iterative path and completes after one edge.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] m_q, m_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] araw_q, araw_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;
    logic        ovf_q, ovf_d;
    logic        pend_q, pend_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_out_q, rd_out_d;

    // Operand decode on the request side
    logic        sgn_a, sgn_b;
    logic        sa, sb;
    logic [31:0] amag, bmag;
    logic        in_dz, in_ovf;
    logic        early_w;

    always_comb begin
        if (funct3[2]) begin
            sgn_a = ~funct3[0];
            sgn_b = ~funct3[0];
        end else begin
            sgn_a = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
            sgn_b = (funct3[1:0] == 2'b01);
        end
    end

    assign sa   = sgn_a & rs1_val[31];
    assign sb   = sgn_b & rs2_val[31];
    assign amag = sa ? -rs1_val : rs1_val;
    assign bmag = sb ? -rs2_val : rs2_val;

    assign in_dz  = funct3[2] && (rs2_val == 32'd0);
    assign in_ovf = funct3[2] && !funct3[0]
                 && (rs1_val == 32'h8000_0000)
                 && (rs2_val == 32'hFFFF_FFFF);

`ifdef MDU_EARLY_OUT_EN
    assign early_w = in_dz | in_ovf
                   | (!funct3[2]
                      && ((rs1_val == 32'd0) || (rs2_val == 32'd0)));
`else
    assign early_w = 1'b0;
`endif

    // One iteration step; the product register doubles as
    // {remainder, quotient} during division.
    logic [31:0] hi, lo;
    logic [32:0] msum;
    logic [32:0] dtmp, ddif;
    logic        dge;
    logic [63:0] mul_step, div_step;

    assign hi   = prod_q[63:32];
    assign lo   = prod_q[31:0];
    assign msum = {1'b0, hi} + ({33{lo[0]}} & {1'b0, m_q});
    assign mul_step = {msum, lo[31:1]};

    assign dtmp = {hi, lo[31]};
    assign ddif = dtmp - {1'b0, m_q};
    assign dge  = (dtmp >= {1'b0, m_q});
    assign div_step = {(dge ? ddif[31:0] : dtmp[31:0]), lo[30:0], dge};

    // Sign fix-up and result selection
    logic [63:0] mul_v;
    logic [31:0] quo_v, rem_v;
    logic [31:0] fix_res, spec_res;

    assign mul_v = neg_q  ? -prod_q : prod_q;
    assign quo_v = neg_q  ? -lo     : lo;
    assign rem_v = rneg_q ? -hi     : hi;

    always_comb begin
        spec_res = 32'd0;
        if (op_q[2]) begin
            if (dz_q)
                spec_res = op_q[1] ? araw_q : 32'hFFFF_FFFF;
            else
                spec_res = op_q[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    always_comb begin
        fix_res = 32'd0;
        unique case (op_q)
            3'b000: fix_res = mul_v[31:0];
            3'b001,
            3'b010,
            3'b011: fix_res = mul_v[63:32];
            3'b100,
            3'b101: fix_res = quo_v;
            3'b110,
            3'b111: fix_res = rem_v;
            default: fix_res = 32'd0;
        endcase
        // Signed divide by zero and overflow need values the
        // magnitude datapath cannot produce after negation.
        if (dz_q || ovf_q)
            fix_res = spec_res;
    end

    // Control
    logic load;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        m_d      = m_q;
        prod_d   = prod_q;
        araw_d   = araw_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        pend_d   = 1'b0;
        result_d = result_q;
        rd_out_d = rd_out_q;
        load     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d  = S_DONE;
                    result_d = spec_res;
                    rd_out_d = rd_q;
                end else if (start) begin
                    load = 1'b1;
                end
            end
            S_CALC: begin
                prod_d = op_q[2] ? div_step : mul_step;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd31)
                    state_d = S_FIX;
            end
            S_FIX: begin
                state_d  = S_DONE;
                result_d = fix_res;
                rd_out_d = rd_q;
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (start)
                    load = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            op_d    = funct3;
            rd_d    = rd;
            araw_d  = rs1_val;
            cnt_d   = 5'd0;
            m_d     = funct3[2] ? bmag : amag;
            prod_d  = {32'd0, (funct3[2] ? amag : bmag)};
            neg_d   = sa ^ sb;
            rneg_d  = sa;
            dz_d    = in_dz;
            ovf_d   = in_ovf;
            // Early-out waits one cycle in IDLE, then reports.
            pend_d  = early_w;
            state_d = early_w ? S_IDLE : S_CALC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 3'd0;
            rd_q     <= 5'd0;
            m_q      <= 32'd0;
            prod_q   <= 64'd0;
            araw_q   <= 32'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            pend_q   <= 1'b0;
            result_q <= 32'd0;
            rd_out_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            m_q      <= m_d;
            prod_q   <= prod_d;
            araw_q   <= araw_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            pend_q   <= pend_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed checks of mul_div_unit (default build).
// Hand-computed vectors, latency, drop/back-to-back issue, reset abort.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    mul_div_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd      (rd),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, then wait (bounded) for done. A nonzero poke
    // drives a competing start sampled at edge E<poke>.
    task automatic run_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] exp,
                          input int poke);
        int n;
        start   = 1'b1;
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd      = r;
        @(posedge clk); #1;
        start   = 1'b0;
        funct3  = ~f;
        rs1_val = ~a;
        rs2_val = b ^ 32'h5A5A_0F0F;
        rd      = ~r;
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && n < 40) begin
            if (n == poke - 1) begin
                start   = 1'b1;
                funct3  = 3'b000;
                rs1_val = 32'd9;
                rs2_val = 32'd9;
                rd      = 5'd31;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk({tag, ".lat"}, n, 32'd33);
        chk({tag, ".res"}, result, exp);
        chk({tag, ".rd"}, {27'd0, rd_out}, {27'd0, r});
    endtask

    initial begin
        int seen;
        rst     = 1'b1;
        start   = 1'b0;
        funct3  = 3'd0;
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        rd      = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.res", result, 32'd0);
        chk("rst.rd", {27'd0, rd_out}, 32'd0);
        rst = 1'b0;

        // Consecutive calls issue during DONE: back-to-back path.
        run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5,
               32'hFFFF_FFEB, 0);
        run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,
               32'hFFFF_FFFE, 0);
        run_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,
               32'h0000_0000, 0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,
               32'hFFFF_FFFF, 0);
        run_op("mulh.min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd9,
               32'h4000_0000, 0);
        run_op("mul.zero", 3'b000, 32'd0, 32'h1234_5678, 5'd10,
               32'd0, 0);
        run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd11,
               32'hFFFF_FFFD, 0);
        run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd12,
               32'hFFFF_FFFF, 0);
        run_op("divu", 3'b101, 32'd100, 32'd7, 5'd13, 32'd14, 0);
        run_op("remu", 3'b111, 32'd100, 32'd7, 5'd14, 32'd2, 0);
        run_op("div.ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15,
               32'h8000_0000, 0);
        run_op("rem.ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16,
               32'd0, 0);
        run_op("divu.dz", 3'b101, 32'd5, 32'd0, 5'd17,
               32'hFFFF_FFFF, 0);
        run_op("rem.dz", 3'b110, 32'd5, 32'd0, 5'd18, 32'd5, 0);
        run_op("div.dzneg", 3'b100, 32'hFFFF_FFFB, 32'd0, 5'd19,
               32'hFFFF_FFFF, 0);
        run_op("rem.dzneg", 3'b110, 32'hFFFF_FFFB, 32'd0, 5'd20,
               32'hFFFF_FFFB, 0);
        run_op("x0", 3'b000, 32'd3, 32'd4, 5'd0, 32'd12, 0);

        // Start at E10 while busy must be dropped.
        run_op("drop", 3'b101, 32'd100, 32'd7, 5'd3, 32'd14, 10);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("drop.noq", seen, 32'd0);
        chk("drop.hold", result, 32'd14);
        chk("drop.rd", {27'd0, rd_out}, 32'd3);

        // Reset in the middle of a divide.
        start   = 1'b1;
        funct3  = 3'b100;
        rs1_val = 32'd1000;
        rs2_val = 32'd3;
        rd      = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("abort.busy0", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.done", {31'd0, done}, 32'd0);
        chk("abort.res", result, 32'd0);
        chk("abort.rd", {27'd0, rd_out}, 32'd0);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("abort.nodone", seen, 32'd0);

        run_op("post", 3'b100, 32'd1000, 32'd3, 5'd21, 32'd333, 0);
        @(posedge clk); #1;
        chk("post.pulse", {31'd0, done}, 32'd0);
        chk("post.hold", result, 32'd333);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
